// File: rtl/mvp_pkg.sv
// Shared constants and types for the MVP read-path blocks.
package mvp_pkg;

    // AXI burst length field width (beats-1)
    localparam int AXI_LEN_W           = 8;

    // Default number of bursts allowed in flight on the DDR read port
    localparam int MAX_OUTSTANDING_DEF = 4;

    // Requester indices as wired inside mvp_top
    typedef enum logic [1:0] {
        REQ_KSK = 2'd0,
        REQ_MAT = 2'd1,
        REQ_VEC = 2'd2
    } req_idx_e;

    // Index of the requester examined at position 'offset' of a round-robin
    // scan that starts just after 'base'
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mvp_rd_arb_fifo.sv
// In-order tag FIFO: remembers which requester owns each accepted burst.
// DEPTH must be a power of two so the pointers wrap naturally.
module mvp_rd_arb_fifo
    import mvp_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == CNT_W'(0));
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // A pop only happens with data present; a push into a full FIFO is only
    // accepted when the same cycle frees a slot.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mvp_rd_arb.sv
// Round-robin arbiter sharing the single DDR AXI read channel among the
// read engines. One AR is held in a register towards DDR; the owner of every
// accepted burst is queued so R beats (returned in order, ID 0) can be
// steered back until rlast.
// Optional build macro: MVP_RD_ARB_PERF_EN adds perf_burst_cnt/perf_stall_cnt.
module mvp_rd_arb
    import mvp_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_arvalid,
    output logic [NUM_REQ-1:0]                   req_arready,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    req_araddr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0]         req_arlen,
    output logic [NUM_REQ-1:0]                   req_rvalid,
    input  logic [NUM_REQ-1:0]                   req_rready,
    output logic [AXI_DATA_WIDTH-1:0]            req_rdata,
    output logic                                 req_rlast,
    output logic                                 data_axi_arvalid,
    input  logic                                 data_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]            data_axi_araddr,
    output logic [AXI_LEN_W-1:0]                 data_axi_arlen,
    input  logic                                 data_axi_rvalid,
    output logic                                 data_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]            data_axi_rdata,
    input  logic                                 data_axi_rlast,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 arb_idle
`ifdef MVP_RD_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_burst_cnt,
    output logic [31:0]                          perf_stall_cnt
`endif
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);

    logic                      ar_valid_r;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_r;
    logic [AXI_LEN_W-1:0]      ar_len_r;
    logic [TAG_W-1:0]          last_grant_r;

    logic                      can_grant_s;
    logic                      grant_s;
    logic [TAG_W-1:0]          winner_s;
    int                        cand_s;
    logic                      hit_s;
    logic [AXI_ADDR_WIDTH-1:0] win_addr_s;
    logic [AXI_LEN_W-1:0]      win_len_s;

    logic [TAG_W-1:0]          head_s;
    logic [OUT_W-1:0]          fifo_count_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      pop_s;

    // The AR slot is free if empty or draining this cycle; a full tag FIFO
    // blocks grants even when a pop happens in the same cycle.
    assign can_grant_s = (~ar_valid_r | data_axi_arready) & ~fifo_full_s;

    // Round-robin scan starting just after the previous winner
    always_comb begin
        grant_s  = 1'b0;
        winner_s = '0;
        cand_s   = 0;
        hit_s    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s   = rr_index(int'(last_grant_r), k, NUM_REQ);
            hit_s    = can_grant_s & ~grant_s & req_arvalid[cand_s];
            winner_s = hit_s ? TAG_W'(cand_s) : winner_s;
            grant_s  = grant_s | hit_s;
        end
    end

    // One-hot accept towards the winning requester and its request payload
    always_comb begin
        req_arready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_arready[i] = grant_s & (winner_s == TAG_W'(i));
        end
        win_addr_s = req_araddr[winner_s*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        win_len_s  = req_arlen[winner_s*AXI_LEN_W +: AXI_LEN_W];
    end

    // R steering: only the burst owner at the FIFO head sees the beat
    always_comb begin
        req_rvalid      = '0;
        data_axi_rready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fifo_empty_s && (head_s == TAG_W'(i))) begin
                req_rvalid[i]   = data_axi_rvalid;
                data_axi_rready = req_rready[i];
            end else begin
                req_rvalid[i]   = 1'b0;
            end
        end
    end

    assign req_rdata = data_axi_rdata;
    assign req_rlast = data_axi_rlast;
    assign pop_s     = data_axi_rvalid & data_axi_rready & data_axi_rlast;

    // AR holding register towards DDR; stays stable until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_valid_r <= 1'b0;
            ar_addr_r  <= '0;
            ar_len_r   <= '0;
        end else if (grant_s) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= win_addr_s;
            ar_len_r   <= win_len_s;
        end else if (data_axi_arready) begin
            ar_valid_r <= 1'b0;
        end else begin
            ar_valid_r <= ar_valid_r;
        end
    end

    // Remember the last winner; reset value gives requester 0 first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= TAG_W'(NUM_REQ-1);
        end else if (grant_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    mvp_rd_arb_fifo #(
        .W     (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_s),
        .din   (winner_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign data_axi_arvalid = ar_valid_r;
    assign data_axi_araddr  = ar_addr_r;
    assign data_axi_arlen   = ar_len_r;
    assign outstanding      = fifo_count_s;
    assign arb_idle         = (fifo_count_s == OUT_W'(0)) & ~ar_valid_r
                              & (req_arvalid == NUM_REQ'(0));

`ifdef MVP_RD_ARB_PERF_EN
    logic [31:0] perf_burst_r;
    logic [31:0] perf_stall_r;

    // Accepted-AR and blocked-request counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_burst_r <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (ar_valid_r && data_axi_arready) begin
                perf_burst_r <= perf_burst_r + 32'd1;
            end else begin
                perf_burst_r <= perf_burst_r;
            end
            if ((req_arvalid != NUM_REQ'(0)) && !grant_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_burst_cnt = perf_burst_r;
    assign perf_stall_cnt = perf_stall_r;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mvp_rd_arb.sv
// Self-checking bench for mvp_rd_arb (NUM_REQ=3, MAX_OUTSTANDING=4).
module tb_mvp_rd_arb;

    localparam int N    = 3;
    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int MAXO = 4;
    localparam int OW   = $clog2(MAXO+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_arvalid;
    logic [N-1:0]      req_arready;
    logic [N*AW-1:0]   req_araddr;
    logic [N*8-1:0]    req_arlen;
    logic [N-1:0]      req_rvalid;
    logic [N-1:0]      req_rready;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic              data_axi_arvalid;
    logic              data_axi_arready;
    logic [AW-1:0]     data_axi_araddr;
    logic [7:0]        data_axi_arlen;
    logic              data_axi_rvalid;
    logic              data_axi_rready;
    logic [DW-1:0]     data_axi_rdata;
    logic              data_axi_rlast;
    logic [OW-1:0]     outstanding;
    logic              arb_idle;
`ifdef MVP_RD_ARB_PERF_EN
    logic [31:0]       perf_burst_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference state: ordered owners of accepted bursts plus the AR slot
    int             q[$];
    bit             m_arv;
    logic [AW-1:0]  m_addr;
    logic [7:0]     m_len;
    int             m_last;

    typedef struct {
        logic [2:0] arvalid;
        logic       rvalid;
        logic       rlast;
        logic [2:0] rready;
        logic [2:0] e_ar;
        logic [2:0] e_rv;
        logic       e_rr;
        int         e_out;
    } vec_t;
    vec_t tv[12];

    mvp_rd_arb #(
        .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rlast(req_rlast),
        .data_axi_arvalid(data_axi_arvalid), .data_axi_arready(data_axi_arready),
        .data_axi_araddr(data_axi_araddr), .data_axi_arlen(data_axi_arlen),
        .data_axi_rvalid(data_axi_rvalid), .data_axi_rready(data_axi_rready),
        .data_axi_rdata(data_axi_rdata), .data_axi_rlast(data_axi_rlast),
        .outstanding(outstanding), .arb_idle(arb_idle)
`ifdef MVP_RD_ARB_PERF_EN
        , .perf_burst_cnt(perf_burst_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_arv  = 1'b0;
        m_addr = '0;
        m_len  = '0;
        m_last = N-1;
    endtask

    task automatic zero_inputs();
        req_arvalid      = '0;
        req_rready       = '0;
        data_axi_arready = 1'b0;
        data_axi_rvalid  = 1'b0;
        data_axi_rlast   = 1'b0;
        data_axi_rdata   = '0;
    endtask

    // Compare every output against the reference, then advance it one cycle
    task automatic tick();
        int win;
        int idx;
        bit can;
        logic [N-1:0] e_ar;
        logic [N-1:0] e_rv;
        logic e_rr;
        #1;
        can = (!m_arv || data_axi_arready) && (q.size() < MAXO);
        win = -1;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (win < 0 && req_arvalid[idx]) win = idx;
            end
        end
        e_ar = '0;
        if (win >= 0) e_ar[win] = 1'b1;
        e_rv = '0;
        e_rr = 1'b0;
        if (q.size() > 0) begin
            e_rr = req_rready[q[0]];
            if (data_axi_rvalid) e_rv[q[0]] = 1'b1;
        end
        chk("m_arready", req_arready, e_ar);
        chk("m_rvalid", req_rvalid, e_rv);
        chk("m_ddr_rready", data_axi_rready, e_rr);
        chk("m_arvalid", data_axi_arvalid, m_arv);
        chk("m_araddr", data_axi_araddr, m_addr);
        chk("m_arlen", data_axi_arlen, m_len);
        chk("m_outstanding", outstanding, q.size());
        chk("m_idle", arb_idle, (q.size() == 0) && !m_arv && (req_arvalid == '0));
        if (data_axi_rvalid && e_rr && data_axi_rlast) void'(q.pop_front());
        if (win >= 0) begin
            q.push_back(win);
            m_arv  = 1'b1;
            m_addr = req_araddr[win*AW +: AW];
            m_len  = req_arlen[win*8 +: 8];
            m_last = win;
        end else if (data_axi_arready) begin
            m_arv = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_arready", req_arready, 3'b000);
        chk("rst_arvalid", data_axi_arvalid, 1'b0);
        chk("rst_araddr", data_axi_araddr, 64'h0);
        chk("rst_arlen", data_axi_arlen, 8'h0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", arb_idle, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tv[0]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 3'b000, 1'b0, 0};
        tv[1]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 1};
        tv[2]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 2};
        tv[3]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 3'b000, 1'b0, 3};
        tv[4]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 4};
        tv[5]  = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b001, 1'b1, 4};
        tv[6]  = '{3'b111, 1'b1, 1'b1, 3'b111, 3'b000, 3'b001, 1'b1, 4};
        tv[7]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 3};
        tv[8]  = '{3'b000, 1'b1, 1'b1, 3'b101, 3'b000, 3'b010, 1'b0, 4};
        tv[9]  = '{3'b000, 1'b1, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 4};
        tv[10] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b100, 1'b1, 3};
        tv[11] = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 2};

        req_araddr = '0;
        req_arlen  = '0;
        zero_inputs();
        model_reset();
        do_reset();

        // Round-robin order, FIFO full and pop-then-grant, R routing
        req_araddr       = {64'h3000, 64'h2000, 64'h1000};
        req_arlen        = {8'd2, 8'd1, 8'd0};
        data_axi_arready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_arvalid     = tv[i].arvalid;
            data_axi_rvalid = tv[i].rvalid;
            data_axi_rlast  = tv[i].rlast;
            req_rready      = tv[i].rready;
            #1;
            chk("tv_arready", req_arready, tv[i].e_ar);
            chk("tv_rvalid", req_rvalid, tv[i].e_rv);
            chk("tv_ddr_rready", data_axi_rready, tv[i].e_rr);
            chk("tv_outstanding", outstanding, tv[i].e_out);
            tick();
        end

        // Single request from requester 1, four-beat burst
        do_reset();
        data_axi_arready    = 1'b1;
        req_araddr[AW +: AW] = 64'h1000;
        req_arlen[8 +: 8]   = 8'd3;
        req_arvalid         = 3'b010;
        #1 chk("single_grant", req_arready, 3'b010);
        tick();
        req_arvalid = '0;
        #1;
        chk("single_araddr", data_axi_araddr, 64'h1000);
        chk("single_arlen", data_axi_arlen, 8'd3);
        chk("single_outstanding", outstanding, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            data_axi_rvalid = 1'b1;
            data_axi_rlast  = (b == 3);
            data_axi_rdata  = DW'(b + 32'h55);
            req_rready      = 3'b111;
            #1;
            chk("single_rvalid", req_rvalid, 3'b010);
            chk("single_rdata", req_rdata[63:0], 64'(b + 32'h55));
            tick();
        end
        zero_inputs();
        #1 chk("single_drained", outstanding, 0);

        // AR backpressure: held AR stays stable and no further grant
        do_reset();
        req_araddr[0 +: AW] = 64'hA000;
        req_arlen[0 +: 8]   = 8'd5;
        req_arvalid         = 3'b001;
        tick();
        req_arvalid          = 3'b100;
        req_araddr[2*AW +: AW] = 64'hC000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_araddr", data_axi_araddr, 64'hA000);
            chk("bp_arlen", data_axi_arlen, 8'd5);
            chk("bp_no_grant", req_arready, 3'b000);
            tick();
        end
        data_axi_arready = 1'b1;
        #1 chk("bp_release_grant", req_arready, 3'b100);
        tick();
        req_arvalid = '0;
        #1 chk("bp_next_addr", data_axi_araddr, 64'hC000);
        tick();

        // R backpressure on head owner (requester 0 not ready)
        data_axi_rvalid = 1'b1;
        data_axi_rlast  = 1'b1;
        req_rready      = 3'b110;
        #1;
        chk("rbp_ddr_rready", data_axi_rready, 1'b0);
        chk("rbp_rvalid", req_rvalid, 3'b001);
        tick();
        tick();
        #1 chk("rbp_outstanding", outstanding, 2);

        // Reset with two bursts outstanding; requester 0 wins first after
        do_reset();
        req_arvalid      = 3'b111;
        data_axi_arready = 1'b1;
        #1 chk("post_reset_winner", req_arready, 3'b001);
        tick();

        // Randomized traffic against the reference
        for (int c = 0; c < 600; c++) begin
            req_arvalid      = N'($urandom_range(0, 7));
            for (int r = 0; r < N; r++) begin
                req_araddr[r*AW +: AW] = {$urandom, $urandom};
                req_arlen[r*8 +: 8]    = 8'($urandom_range(0, 255));
            end
            req_rready       = N'($urandom_range(0, 7));
            data_axi_arready = ($urandom_range(0, 3) != 0);
            data_axi_rvalid  = ($urandom_range(0, 2) != 0);
            data_axi_rlast   = ($urandom_range(0, 2) == 0);
            data_axi_rdata   = DW'($urandom);
            tick();
        end

`ifdef MVP_RD_ARB_PERF_EN
        // 10 accepted bursts with 3 blocked cycles
        do_reset();
        req_arvalid = 3'b001;
        for (int c = 0; c < 4; c++) tick();
        data_axi_arready = 1'b1;
        data_axi_rvalid  = 1'b1;
        data_axi_rlast   = 1'b1;
        req_rready       = 3'b111;
        for (int c = 0; c < 9; c++) tick();
        req_arvalid = '0;
        tick();
        #1;
        chk("perf_burst", perf_burst_cnt, 32'd10);
        chk("perf_stall", perf_stall_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
